// File: rtl/flag_pkg.sv
// flag_pkg: op encodings, flag vector layout and default width shared by the flag path.
package flag_pkg;
  localparam int DEF_W = 32;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHR = 3'd5,
    OP_MOV = 3'd6,
    OP_MUL = 3'd7
  } op_e;
  // Field order matches the flag_registers port order, zf in the MSB.
  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
    logic uf;
    logic cffw;
    logic cfhl;
    logic cfhh;
    logic df;
    logic hwf;
    logic srf;
    logic mvf;
    logic mcf;
    logic tf;
  } flags_t;
endpackage

// File: rtl/flag_mul_iter.sv
// flag_mul_iter: iterative shift-add multiplier, STEPS chunks of multiplier bits per operation.
module flag_mul_iter import flag_pkg::*; #(
  parameter int W = DEF_W,
  parameter int STEPS = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);
  localparam int K = (W + STEPS - 1) / STEPS;
  localparam int CW = $clog2(STEPS + 1);
  logic [CW-1:0] cnt;
  logic [2*W-1:0] acc, mcand, part;
  logic [W-1:0] mplier;
  always_comb begin
    part = '0;
    for (int i = 0; i < K; i++)
      if (mplier[i]) part = part + (mcand << i);
  end
  // The final chunk is folded in combinationally so the caller can write on done.
  assign product = acc + part;
  assign done = cnt == CW'(1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
    end else if (start) begin
      cnt <= CW'(STEPS);
      acc <= '0;
      mcand <= {{W{1'b0}}, a};
      mplier <= b;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      acc <= product;
      mcand <= mcand << K;
      mplier <= mplier >> K;
    end
  end
endmodule

// File: rtl/flag_gen.sv
// flag_gen: computes an op result and its status flags, presented with a one-cycle write pulse.
module flag_gen import flag_pkg::*; #(
  parameter int W = DEF_W,
  parameter int MUL_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic         half,
  input  logic         trap_en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         flags_we,
  output logic         zf,
  output logic         sf,
  output logic         of,
  output logic         uf,
  output logic         cffw,
  output logic         cfhl,
  output logic         cfhh,
  output logic         df,
  output logic         hwf,
  output logic         srf,
  output logic         mvf,
  output logic         mcf,
  output logic         tf
);
  localparam int H = W / 2;
  localparam int SW = $clog2(W);
  typedef enum logic {IDLE, MUL_BUSY} state_e;
  state_e state, state_nx;
  flags_t fl, f_nx;
  logic [W-1:0] bb, sum, alu_r, r_nx;
  logic [H:0] lo, hi;
  logic [2*W-1:0] prod;
  logic acc, sub, addsub, carry_hi, ov_lo, ov_hi, mul_done, we_nx, trap_q;
  assign in_ready = state == IDLE;
  assign acc = in_valid && in_ready;
  assign sub = op == OP_SUB;
  assign addsub = op == OP_ADD || sub;
  assign bb = sub ? ~b : b;
  // Half mode cuts the carry chain; each half gets the SUB carry-in on its own.
  assign lo = {1'b0, a[H-1:0]} + {1'b0, bb[H-1:0]} + {{H{1'b0}}, sub};
  assign carry_hi = half ? sub : lo[H];
  assign hi = {1'b0, a[W-1:H]} + {1'b0, bb[W-1:H]} + {{H{1'b0}}, carry_hi};
  assign sum = {hi[H-1:0], lo[H-1:0]};
  assign ov_lo = a[H-1] == bb[H-1] && sum[H-1] != a[H-1];
  assign ov_hi = a[W-1] == bb[W-1] && sum[W-1] != a[W-1];
  assign alu_r = addsub ? sum :
                 op == OP_AND ? a & b :
                 op == OP_OR ? a | b :
                 op == OP_XOR ? a ^ b :
                 op == OP_SHR ? a >> b[SW-1:0] : a;
  flag_mul_iter #(.W(W), .STEPS(MUL_CYCLES - 1)) u_mul (
    .clk(clk),
    .rst_n(rst_n),
    .start(acc && op == OP_MUL),
    .a(a),
    .b(b),
    .done(mul_done),
    .product(prod)
  );
  always_comb begin
    state_nx = state;
    we_nx = 1'b0;
    f_nx = '0;
    r_nx = alu_r;
    if (state == MUL_BUSY) begin
      r_nx = prod[W-1:0];
      f_nx.of = |prod[2*W-1:W];
      f_nx.mcf = 1'b1;
      f_nx.tf = f_nx.of && trap_q;
      we_nx = mul_done;
      state_nx = mul_done ? IDLE : MUL_BUSY;
    end else if (acc) begin
      we_nx = op != OP_MUL;
      state_nx = op == OP_MUL ? MUL_BUSY : IDLE;
      f_nx.of = addsub && (ov_hi || (half && ov_lo));
      f_nx.uf = sub && (!hi[H] || (half && !lo[H]));
      f_nx.cffw = addsub && !half && hi[H];
      f_nx.cfhl = addsub && lo[H];
      f_nx.cfhh = addsub && hi[H];
      f_nx.df = op == OP_SHR;
      f_nx.srf = op == OP_SHR && |b[SW-1:0];
      f_nx.mvf = op == OP_MOV;
      f_nx.hwf = addsub && half;
      f_nx.tf = f_nx.of && trap_en;
    end
    f_nx.zf = r_nx == '0;
    f_nx.sf = r_nx[W-1];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      result <= '0;
      fl <= '0;
      flags_we <= 1'b0;
      trap_q <= 1'b0;
    end else begin
      state <= state_nx;
      flags_we <= we_nx;
      if (we_nx) begin
        result <= r_nx;
        fl <= f_nx;
      end
      if (acc) trap_q <= trap_en;
    end
  end
  assign {zf, sf, of, uf, cffw, cfhl, cfhh, df, hwf, srf, mvf, mcf, tf} = fl;
endmodule

// File: tb/tb_flag_gen.sv
// tb_flag_gen: directed vector table plus hand-written MUL, back-to-back and reset sequences.
module tb_flag_gen;
  import flag_pkg::*;
  localparam int W = 32;
  localparam logic [12:0] ZF = 13'h1000, SF = 13'h0800, OF = 13'h0400, UF = 13'h0200;
  localparam logic [12:0] CFFW = 13'h0100, CFHL = 13'h0080, CFHH = 13'h0040, DF = 13'h0020;
  localparam logic [12:0] HWF = 13'h0010, SRF = 13'h0008, MVF = 13'h0004, MCF = 13'h0002, TF = 13'h0001;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, half = 1'b0, trap_en = 1'b0;
  logic [2:0] op = 3'd0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, flags_we;
  logic [W-1:0] result;
  logic zf, sf, of, uf, cffw, cfhl, cfhh, df, hwf, srf, mvf, mcf, tf;
  logic [12:0] fl;
  int pass = 0, total = 0;
  assign fl = {zf, sf, of, uf, cffw, cfhl, cfhh, df, hwf, srf, mvf, mcf, tf};
  flag_gen #(.W(W), .MUL_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .half(half), .trap_en(trap_en), .a(a), .b(b), .result(result), .flags_we(flags_we),
    .zf(zf), .sf(sf), .of(of), .uf(uf), .cffw(cffw), .cfhl(cfhl), .cfhh(cfhh),
    .df(df), .hwf(hwf), .srf(srf), .mvf(mvf), .mcf(mcf), .tf(tf)
  );
  always #5 clk = ~clk;
  typedef struct {
    string nm;
    logic [2:0] op;
    logic half;
    logic trap;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic [12:0] f;
  } vec_t;
  vec_t v[13];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass++;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [2:0] o, input logic h, input logic t, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o;
    half = h;
    trap_en = t;
    a = x;
    b = y;
    in_valid = 1'b1;
  endtask
  initial begin
    int n;
    v[0]  = '{"add_ovf",   OP_ADD, 1'b0, 1'b1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, SF | OF | CFHL | TF};
    v[1]  = '{"sub_eq",    OP_SUB, 1'b0, 1'b0, 32'h00000005, 32'h00000005, 32'h00000000, ZF | CFFW | CFHL | CFHH};
    v[2]  = '{"sub_brw",   OP_SUB, 1'b0, 1'b0, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, SF | UF};
    v[3]  = '{"add_half",  OP_ADD, 1'b1, 1'b0, 32'h0001FFFF, 32'h00010001, 32'h00020000, CFHL | HWF};
    v[4]  = '{"and",       OP_AND, 1'b0, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, SF};
    v[5]  = '{"or_zero",   OP_OR,  1'b0, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, ZF};
    v[6]  = '{"xor",       OP_XOR, 1'b0, 1'b0, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 13'h0};
    v[7]  = '{"shr4",      OP_SHR, 1'b0, 1'b0, 32'h80000000, 32'h00000004, 32'h08000000, DF | SRF};
    v[8]  = '{"shr0",      OP_SHR, 1'b0, 1'b0, 32'h12345678, 32'h00000020, 32'h12345678, DF};
    v[9]  = '{"mov",       OP_MOV, 1'b0, 1'b0, 32'hDEADBEEF, 32'h00001234, 32'hDEADBEEF, SF | MVF};
    v[10] = '{"add_wrap",  OP_ADD, 1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h00000000, ZF | OF | CFFW | CFHH};
    v[11] = '{"sub_half",  OP_SUB, 1'b1, 1'b0, 32'h00010005, 32'h00020003, 32'hFFFF0002, SF | UF | CFHL | HWF};
    v[12] = '{"half_ovf",  OP_ADD, 1'b1, 1'b1, 32'h00007FFF, 32'h00000001, 32'h00008000, OF | HWF | TF};
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    chk("rst_result", 64'(result), 64'h0);
    chk("rst_flags", 64'(fl), 64'h0);
    chk("rst_we", 64'(flags_we), 64'h0);
    chk("rst_ready", 64'(in_ready), 64'h1);
    for (int i = 0; i < 13; i++) begin
      drive(v[i].op, v[i].half, v[i].trap, v[i].a, v[i].b);
      tick;
      in_valid = 1'b0;
      chk({v[i].nm, "_we"}, 64'(flags_we), 64'h1);
      chk({v[i].nm, "_r"}, 64'(result), 64'(v[i].r));
      chk({v[i].nm, "_f"}, 64'(fl), 64'(v[i].f));
      tick;
      chk({v[i].nm, "_we_off"}, 64'(flags_we), 64'h0);
      chk({v[i].nm, "_hold"}, 64'(result), 64'(v[i].r));
    end
    drive(OP_ADD, 1'b0, 1'b0, 32'd1, 32'd2);
    tick;
    chk("b2b_we1", 64'(flags_we), 64'h1);
    chk("b2b_r1", 64'(result), 64'h3);
    drive(OP_AND, 1'b0, 1'b0, 32'd6, 32'd3);
    tick;
    in_valid = 1'b0;
    chk("b2b_we2", 64'(flags_we), 64'h1);
    chk("b2b_r2", 64'(result), 64'h2);
    tick;
    chk("b2b_we_off", 64'(flags_we), 64'h0);
    drive(OP_MUL, 1'b0, 1'b1, 32'h00010000, 32'h00010000);
    tick;
    for (int i = 0; i < 3; i++) begin
      chk("mul_busy_ready", 64'(in_ready), 64'h0);
      chk("mul_busy_we", 64'(flags_we), 64'h0);
      if (i == 0) drive(OP_ADD, 1'b0, 1'b0, 32'd1, 32'd1);
      tick;
    end
    in_valid = 1'b0;
    chk("mul_we", 64'(flags_we), 64'h1);
    chk("mul_ready", 64'(in_ready), 64'h1);
    chk("mul_r", 64'(result), 64'h0);
    chk("mul_f", 64'(fl), 64'(ZF | OF | MCF | TF));
    tick;
    chk("mul_no_extra", 64'(flags_we), 64'h0);
    chk("mul_hold", 64'(result), 64'h0);
    drive(OP_MUL, 1'b0, 1'b0, 32'h00012345, 32'h00006789);
    tick;
    in_valid = 1'b0;
    n = 1;
    while (!flags_we && n < 10) begin
      tick;
      n++;
    end
    chk("mul2_latency", 64'(n), 64'd4);
    chk("mul2_r", 64'(result), 64'h75CCA2ED);
    chk("mul2_f", 64'(fl), 64'(MCF));
    drive(OP_MUL, 1'b0, 1'b1, 32'd3, 32'd3);
    tick;
    in_valid = 1'b0;
    tick;
    rst_n = 1'b0;
    tick;
    chk("abort_r", 64'(result), 64'h0);
    chk("abort_f", 64'(fl), 64'h0);
    chk("abort_we", 64'(flags_we), 64'h0);
    chk("abort_ready", 64'(in_ready), 64'h1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("abort_quiet", 64'(flags_we), 64'h0);
    end
    drive(OP_ADD, 1'b0, 1'b0, 32'd1, 32'd1);
    tick;
    in_valid = 1'b0;
    chk("post_we", 64'(flags_we), 64'h1);
    chk("post_r", 64'(result), 64'h2);
    chk("post_f", 64'(fl), 64'h0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
